// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave: FSM encoding, default widths and command codes.
package spi_pkg;

    localparam int WORD_W_DEF = 10;
    localparam int DATA_W_DEF = 8;

    localparam logic [1:0] CMD_WR_ADDR = 2'b00;
    localparam logic [1:0] CMD_WR_DATA = 2'b01;
    localparam logic [1:0] CMD_RD_ADDR = 2'b10;
    localparam logic [1:0] CMD_RD_DATA = 2'b11;

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        CHK_CMD   = 3'd1,
        WRITE     = 3'd2,
        READ_ADD  = 3'd3,
        READ_DATA = 3'd4
    } state_t;

    // The first bit of a word selects write vs read; rd_addr_flag picks which read phase.
    function automatic state_t dispatch(input logic cmd_msb, input logic addr_seen);
        if (cmd_msb != CMD_RD_ADDR[1]) return WRITE;
        else if (!addr_seen)           return READ_ADD;
        else                           return READ_DATA;
    endfunction

endpackage

// File: rtl/spi_shift_out.sv
// MISO serialiser: loads a read word and shifts it out MSB first over DATA_W cycles.
module spi_shift_out
    import spi_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              clear,
    input  logic              load,
    input  logic [DATA_W-1:0] data,
    output logic              miso,
    output logic              done
);

    localparam logic [2:0] LAST = 3'(DATA_W - 1);

    logic [DATA_W-1:0] sreg;
    logic [2:0]        cnt;
    logic              active;

    // High on the edge that retires the final bit, so the owner can react in the same cycle.
    assign done = active && (cnt == LAST);

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            sreg   <= '0;
            cnt    <= '0;
            active <= 1'b0;
            miso   <= 1'b0;
        end else if (load) begin
            sreg   <= {data[DATA_W-2:0], 1'b0};
            miso   <= data[DATA_W-1];
            cnt    <= '0;
            active <= 1'b1;
        end else if (active) begin
            if (cnt == LAST) begin
                miso   <= 1'b0;
                active <= 1'b0;
                cnt    <= '0;
            end else begin
                miso <= sreg[DATA_W-1];
                sreg <= sreg << 1;
                cnt  <= cnt + 3'd1;
            end
        end
    end

endmodule

// File: rtl/spi_slave.sv
// SPI slave front end for a RAM: deserialises 10-bit command words and serialises read data.
module spi_slave
    import spi_pkg::*;
#(
    parameter int WORD_W = WORD_W_DEF,
    parameter int DATA_W = DATA_W_DEF
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              SS_n,
    input  logic              MOSI,
    output logic              MISO,
    output logic [WORD_W-1:0] rx_data,
    output logic              rx_valid,
    input  logic [DATA_W-1:0] tx_data,
    input  logic              tx_valid,
    output state_t            state,
    output logic              rd_addr_flag
);

    localparam int CNT_W = $clog2(WORD_W);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(WORD_W - 2);

    logic [WORD_W-2:0] shreg;
    logic [CNT_W-1:0]  bit_cnt;
    logic              word_done;
    logic              tx_taken;
    logic              tx_load;
    logic              shift_done;

    // Only the first tx_valid after the word is accepted; later pulses in the frame are ignored.
    assign tx_load = (state == READ_DATA) && word_done && !tx_taken && tx_valid && !SS_n;

    spi_shift_out #(.DATA_W(DATA_W)) u_shift_out (
        .clk   (clk),
        .rst   (rst),
        .clear (SS_n),
        .load  (tx_load),
        .data  (tx_data),
        .miso  (MISO),
        .done  (shift_done)
    );

    always_ff @(posedge clk) begin
        rx_valid <= 1'b0;
        if (rst) begin
            state        <= IDLE;
            rx_data      <= '0;
            rx_valid     <= 1'b0;
            shreg        <= '0;
            bit_cnt      <= '0;
            word_done    <= 1'b0;
            tx_taken     <= 1'b0;
            rd_addr_flag <= 1'b0;
        end else if (SS_n && state != IDLE) begin
            state     <= IDLE;
            shreg     <= '0;
            bit_cnt   <= '0;
            word_done <= 1'b0;
            tx_taken  <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (!SS_n) state <= CHK_CMD;
                end
                CHK_CMD: begin
                    shreg     <= {{(WORD_W-2){1'b0}}, MOSI};
                    bit_cnt   <= '0;
                    word_done <= 1'b0;
                    tx_taken  <= 1'b0;
                    state     <= dispatch(MOSI, rd_addr_flag);
                end
                WRITE, READ_ADD, READ_DATA: begin
                    if (!word_done) begin
                        shreg   <= {shreg[WORD_W-3:0], MOSI};
                        bit_cnt <= bit_cnt + CNT_W'(1);
                        if (bit_cnt == LAST_BIT) begin
                            rx_data   <= {shreg, MOSI};
                            rx_valid  <= 1'b1;
                            word_done <= 1'b1;
                            bit_cnt   <= '0;
                            if (state == READ_ADD) rd_addr_flag <= 1'b1;
                        end
                    end
                    if (state == READ_DATA) begin
                        if (tx_load)    tx_taken     <= 1'b1;
                        if (shift_done) rd_addr_flag <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_slave.sv
// Directed and randomised frames against a word-level model of the SPI slave protocol.
module tb_spi_slave;
    import spi_pkg::*;

    localparam int WORD_W = 10;
    localparam int DATA_W = 8;

    logic              clk = 1'b0;
    logic              rst;
    logic              SS_n;
    logic              MOSI;
    logic              MISO;
    logic [WORD_W-1:0] rx_data;
    logic              rx_valid;
    logic [DATA_W-1:0] tx_data;
    logic              tx_valid;
    state_t            state;
    logic              rd_addr_flag;

    int total = 0;
    int bad   = 0;
    logic              exp_flag = 1'b0;
    logic [WORD_W-1:0] last_rx  = '0;

    always #5 clk = ~clk;

    spi_slave #(.WORD_W(WORD_W), .DATA_W(DATA_W)) dut (
        .clk          (clk),
        .rst          (rst),
        .SS_n         (SS_n),
        .MOSI         (MOSI),
        .MISO         (MISO),
        .rx_data      (rx_data),
        .rx_valid     (rx_valid),
        .tx_data      (tx_data),
        .tx_valid     (tx_valid),
        .state        (state),
        .rd_addr_flag (rd_addr_flag)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Full frame: one IDLE cycle, then 10 bits MSB first; ends on the rx_valid cycle.
    task automatic send_frame(input logic [WORD_W-1:0] w, output state_t exp_st);
        if (!w[WORD_W-1])  exp_st = WRITE;
        else if (exp_flag) exp_st = READ_DATA;
        else               exp_st = READ_ADD;
        SS_n = 1'b0;
        MOSI = 1'($urandom_range(0, 1));
        tick;
        check("enter_chk_cmd", state, CHK_CMD);
        for (int i = WORD_W - 1; i >= 0; i--) begin
            MOSI = w[i];
            tick;
            if (i == WORD_W - 1) check("dispatch_state", state, exp_st);
            check("miso_during_rx", MISO, 0);
            check("rx_valid_timing", rx_valid, (i == 0));
        end
        check("rx_data_word", rx_data, w);
        last_rx = w;
        if (exp_st == READ_ADD) exp_flag = 1'b1;
        check("rd_addr_flag_after_word", rd_addr_flag, exp_flag);
    endtask

    task automatic end_frame;
        SS_n     = 1'b1;
        tx_valid = 1'b0;
        tick;
        check("end_state_idle", state, IDLE);
        check("end_miso_zero", MISO, 0);
        check("end_rx_valid", rx_valid, 0);
        check("end_rx_data_hold", rx_data, last_rx);
    endtask

    // Called on the rx_valid cycle of a READ_DATA word. stop_at < 8 leaves mid-shift.
    task automatic serve_read(input logic [DATA_W-1:0] d, input int wait_c, input int hold,
                              input int stop_at);
        for (int i = 0; i < wait_c; i++) begin
            tx_valid = 1'b0;
            tick;
            check("miso_wait_zero", MISO, 0);
        end
        tx_valid = 1'b1;
        tx_data  = d;
        tick;
        for (int i = 0; i < DATA_W; i++) begin
            if (i == stop_at) return;
            check("miso_bit", MISO, 32'((d >> (DATA_W - 1 - i)) & 8'd1));
            tx_valid = (i + 1 < hold);
            tx_data  = DATA_W'($urandom) | 8'h01;
            tick;
        end
        check("miso_after_shift", MISO, 0);
        exp_flag = 1'b0;
        check("flag_cleared", rd_addr_flag, exp_flag);
        tx_valid = 1'b1;
        tx_data  = 8'hFF;
        tick;
        check("late_tx_valid_ignored", MISO, 0);
        tx_valid = 1'b0;
    endtask

    task automatic abort_frame(input logic [WORD_W-1:0] w, input int nbits);
        SS_n = 1'b0;
        tick;
        for (int i = 0; i < nbits; i++) begin
            MOSI = w[WORD_W-1-i];
            tick;
            check("abort_no_rx_valid", rx_valid, 0);
        end
        SS_n = 1'b1;
        tick;
        check("abort_state_idle", state, IDLE);
        check("abort_rx_valid", rx_valid, 0);
        check("abort_rx_data_hold", rx_data, last_rx);
        check("abort_flag_kept", rd_addr_flag, exp_flag);
        check("abort_miso_zero", MISO, 0);
    endtask

    initial begin
        state_t st;
        logic [WORD_W-1:0] w;
        logic [DATA_W-1:0] d;

        rst = 1'b1; SS_n = 1'b0; MOSI = 1'b1; tx_valid = 1'b1; tx_data = 8'hFF;
        tick;
        tick;
        check("reset_state", state, IDLE);
        check("reset_rx_data", rx_data, 0);
        check("reset_rx_valid", rx_valid, 0);
        check("reset_miso", MISO, 0);
        check("reset_flag", rd_addr_flag, 0);
        rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
        tick;

        // Write address, with trailing MOSI bits that must be ignored.
        send_frame(10'h005, st);
        for (int i = 0; i < 3; i++) begin
            MOSI = 1'($urandom_range(0, 1));
            tick;
            check("write_trailing_ignored", rx_valid, 0);
            check("write_rx_data_hold", rx_data, 10'h005);
        end
        end_frame();

        send_frame(10'h1AA, st);
        end_frame();

        // Read address then read data 0xAA, tx_valid two cycles after rx_valid.
        send_frame(10'h205, st);
        end_frame();
        send_frame({2'b11, 8'($urandom)}, st);
        serve_read(8'hAA, 2, 1, DATA_W);
        end_frame();

        // Held tx_valid with changing data: only the first value is serialised.
        send_frame(10'h2C1, st);
        end_frame();
        send_frame(10'h3C1, st);
        serve_read(8'h3C, 0, 3, DATA_W);
        end_frame();

        // Aborted write frame followed back-to-back by a complete one.
        abort_frame(10'h0F3, 5);
        send_frame(10'h133, st);
        end_frame();

        // Aborted READ_DATA keeps the flag; the retried read still works.
        send_frame(10'h277, st);
        end_frame();
        abort_frame(10'h3FF, 4);
        send_frame(10'h300, st);
        serve_read(8'h5A, 1, 1, DATA_W);
        end_frame();

        // Reset during shift-out after three MISO bits.
        send_frame(10'h211, st);
        end_frame();
        send_frame(10'h322, st);
        serve_read(8'hE7, 0, 1, 3);
        rst = 1'b1; SS_n = 1'b0; tx_valid = 1'b1;
        tick;
        exp_flag = 1'b0;
        last_rx  = '0;
        check("midreset_miso", MISO, 0);
        check("midreset_flag", rd_addr_flag, 0);
        check("midreset_state", state, IDLE);
        check("midreset_rx_valid", rx_valid, 0);
        rst = 1'b0; SS_n = 1'b1; tx_valid = 1'b0;
        tick;
        send_frame(10'h3A5, st);
        check("after_reset_read_add", st, READ_ADD);
        end_frame();
        send_frame(10'h3A5, st);
        serve_read(8'h81, 0, 1, DATA_W);
        end_frame();

        // Random mix of writes, read pairs and aborts.
        for (int n = 0; n < 16; n++) begin
            w = WORD_W'($urandom);
            d = DATA_W'($urandom);
            case ($urandom_range(0, 2))
                0: begin
                    w[WORD_W-1] = 1'b0;
                    send_frame(w, st);
                    end_frame();
                end
                1: begin
                    w[WORD_W-1] = 1'b1;
                    send_frame(w, st);
                    if (st == READ_ADD) begin
                        end_frame();
                        w = WORD_W'($urandom) | 10'h200;
                        send_frame(w, st);
                    end
                    serve_read(d, $urandom_range(0, 3), $urandom_range(1, 3), DATA_W);
                    end_frame();
                end
                default: abort_frame(w, $urandom_range(1, WORD_W - 1));
            endcase
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
